glitchless_clk_div_switch: RTL and testbench
============================================

// Module: glitchless_clk_div_switch
// PURPOSE
//  Parametrised clock divider: derives clk_out from clk by an integer ratio that can be
//  changed at run time without glitches or runt phases. Ratio changes and start/stop
//  happen only on period boundaries, so no high or low phase is ever truncated.
//  Sits in the clock-generation area as the source of divided functional clocks.
//  Also drives a matching clock-enable (tick) for logic that stays on clk.
// PARAMETERS
//  DIV_W    8  width of divide-ratio fields; max ratio 2**DIV_W-1
//  DEF_DIV  2  ratio loaded at reset; legal range 2..2**DIV_W-1
// PORTS
//  clk        in   1      source clock; all logic on posedge clk
//  rst        in   1      synchronous reset, active-high
//  en         in   1      1 = run divider; 0 = stop at end of current period, clk_out low
//  div_req    in   1      new ratio request (valid)
//  div_val    in   DIV_W  requested ratio; sampled when div_req & div_ready
//  div_ready  out  1      request can be accepted this cycle
//  div_err    out  1      1-cycle pulse: accepted div_val was <2, clamped to 2
//  clk_out    out  1      divided clock; registered, glitch-free
//  tick       out  1      1-cycle pulse in the first clk cycle of each clk_out period
//  running    out  1      1 while periods are being generated
//  cur_div    out  DIV_W  ratio currently in effect
// BEHAVIOUR
//  Reset (sync, rst=1): state IDLE; cnt=0; clk_out=0; tick=0; running=0; div_ready=1;
//   div_err=0; cur_div=DEF_DIV; pending cleared. rst mid-period aborts: clk_out=0 next edge.
//  States: IDLE (clk_out=0, cnt=0), RUN.
//   IDLE->RUN when en=1: next edge clk_out=1, tick=1, cnt=0, running=1 (latency 1 cycle).
//   RUN->IDLE at period end (cnt==cur_div-1) when en=0 at that edge; clk_out is already low.
//   en toggled mid-period is ignored until period end.
//  Waveform in RUN, N=cur_div: cnt counts 0..N-1 and wraps.
//   clk_out=1 for cnt<floor(N/2), else 0: high floor(N/2), low ceil(N/2) cycles.
//   Example: N=3 -> 1 high, 2 low. N=2 -> 1/1.
//   tick=1 exactly when cnt==0 (same cycle as clk_out rising).
//  Ratio handshake: transfer when div_req & div_ready.
//   Value <2 is stored as 2 and div_err pulses the next cycle.
//   In IDLE: cur_div updates next edge; div_ready stays 1.
//   In RUN: value held pending; div_ready=0 until applied. Applied on the edge where
//    cnt==cur_div-1, so the next period (cnt=0) uses the new N. div_ready returns to 1
//    on that same edge.
//   Only one pending value; while div_ready=0, div_req is ignored (no overwrite).
//  Simultaneous: pending apply and en=0 at the same period end -> both take effect:
//   cur_div updated and state IDLE. A request accepted in the same cycle as IDLE->RUN
//   is applied immediately, so the first period uses the new value.
//  Guarantees: no clk_out high or low phase shorter than floor(min(old,new)/2) cycles;
//   clk_out changes only from a flop.
// TESTING
//  1 rst, en=1, no req -> clk_out 1,0,1,0..; tick every 2nd cycle; cur_div=2; running=1.
//  2 RUN N=4; req div_val=7 at cnt=1 -> div_ready=0 until cnt=3 edge; next period
//    high 3 / low 4; tick spacing goes 4 -> 7; no short phase.
//  3 RUN N=5; en=0 at cnt=1 -> periods complete (2 high, 3 low); IDLE, clk_out=0,
//    running=0; en=1 -> clk_out=1 and tick one cycle later.
//  4 IDLE; req div_val=0, then 1 -> each stored as 2; div_err pulses; cur_div=2.
//  5 RUN N=6; rst at cnt=2 -> next edge clk_out=0, cur_div=DEF_DIV, div_ready=1, IDLE.
//  6 RUN N=3; req during pending -> ignored; en=0 at apply edge -> IDLE with new cur_div.

Source files
------------

// File: rtl/glitchless_clk_div_switch.sv
// Integer clock divider with run-time ratio changes and start/stop applied only at period boundaries.
// Also produces a clk-domain tick aligned with each clk_out rising edge.
module glitchless_clk_div_switch #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ready,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic             state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] pend_val;
  logic             pend;
  logic             accept;
  logic             val_low;
  logic [DIV_W-1:0] req_div;
  logic             period_end;

  assign div_ready  = !pend;
  assign accept     = div_req && div_ready;
  assign val_low    = div_val < DIV_W'(2);
  assign req_div    = val_low ? DIV_W'(2) : div_val;
  assign cnt_inc    = cnt + 1'b1;
  assign period_end = (state == RUN) && (cnt == cur_div - 1'b1);
  assign running    = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      cur_div  <= DIV_W'(DEF_DIV);
      pend     <= 1'b0;
      pend_val <= '0;
      div_err  <= 1'b0;
    end else begin
      div_err <= accept && val_low;
      if (state == IDLE) begin
        // A request accepted together with start is already in cur_div for the first period.
        if (accept) cur_div <= req_div;
        cnt <= '0;
        if (en) begin
          state   <= RUN;
          clk_out <= 1'b1;
          tick    <= 1'b1;
        end else begin
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      end else if (period_end) begin
        if (pend) begin
          cur_div <= pend_val;
          pend    <= 1'b0;
        end else if (accept) begin
          cur_div <= req_div;
        end
        cnt <= '0;
        if (en) begin
          clk_out <= 1'b1;
          tick    <= 1'b1;
        end else begin
          state   <= IDLE;
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      end else begin
        // Mid-period: ratio only parked, so the running period keeps its shape.
        cnt     <= cnt_inc;
        clk_out <= cnt_inc < (cur_div >> 1);
        tick    <= 1'b0;
        if (accept) begin
          pend     <= 1'b1;
          pend_val <= req_div;
        end
      end
    end
  end

endmodule

// File: tb/tb_glitchless_clk_div_switch.sv
// Cycle-by-cycle vector check of glitchless_clk_div_switch; expectations queued at drive time.
module tb_glitchless_clk_div_switch;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ready, div_err, clk_out, tick, running;
  logic [DIV_W-1:0] cur_div;

  glitchless_clk_div_switch #(.DIV_W(DIV_W), .DEF_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .div_req(div_req), .div_val(div_val),
    .div_ready(div_ready), .div_err(div_err), .clk_out(clk_out), .tick(tick),
    .running(running), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, req;
    logic [7:0] val;
    logic       co, tk, rn, rdy, er;
    logic [7:0] cd;
  } vec_t;

  vec_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec_no = 0;

  function automatic vec_t v(logic r, logic e, logic q, logic [7:0] d,
                             logic co, logic tk, logic rn, logic rdy, logic er, logic [7:0] cd);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.val = d;
    t.co = co; t.tk = tk; t.rn = rn; t.rdy = rdy; t.er = er; t.cd = cd;
    return t;
  endfunction

  task automatic chk(string name, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0d, want %0d", vec_no, name, got, want);
    end
  endtask

  // One clk cycle: drive at negedge, expectation queued, outputs compared #1 after posedge.
  task automatic apply(vec_t t);
    vec_t e;
    @(negedge clk);
    rst = t.rst; en = t.en; div_req = t.req; div_val = t.val;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("clk_out",   clk_out,   e.co);
    chk("tick",      tick,      e.tk);
    chk("running",   running,   e.rn);
    chk("div_ready", div_ready, e.rdy);
    chk("div_err",   div_err,   e.er);
    chk("cur_div",   cur_div,   e.cd);
    vec_no++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; en = 1'b0; div_req = 1'b0; div_val = '0;

    //             rst en req val  co tk rn rdy er cd
    // free-running N=2 after reset
    tbl.push_back(v(1, 0, 0, 0,    0, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,    1, 1, 1, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,    0, 0, 1, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,    1, 1, 1, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,    0, 0, 1, 1, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,    1, 1, 1, 1, 0, 2));
    // IDLE ratio loads, clamping of 0 and 1, max ratio
    tbl.push_back(v(1, 0, 0, 0,    0, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 0, 1, 5,    0, 0, 0, 1, 0, 5));
    tbl.push_back(v(0, 0, 1, 0,    0, 0, 0, 1, 1, 2));
    tbl.push_back(v(0, 0, 1, 9,    0, 0, 0, 1, 0, 9));
    tbl.push_back(v(0, 0, 1, 1,    0, 0, 0, 1, 1, 2));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 0, 1, 255,  0, 0, 0, 1, 0, 255));
    tbl.push_back(v(1, 0, 0, 0,    0, 0, 0, 1, 0, 2));
    // N=6, reset at cnt=2 aborts the period
    tbl.push_back(v(0, 0, 1, 6,    0, 0, 0, 1, 0, 6));
    tbl.push_back(v(0, 1, 0, 0,    1, 1, 1, 1, 0, 6));
    tbl.push_back(v(0, 1, 0, 0,    1, 0, 1, 1, 0, 6));
    tbl.push_back(v(0, 1, 0, 0,    1, 0, 1, 1, 0, 6));
    tbl.push_back(v(1, 1, 0, 0,    0, 0, 0, 1, 0, 2));
    // request with start: first period already N=3 (1 high, 2 low), then stop
    tbl.push_back(v(0, 1, 1, 3,    1, 1, 1, 1, 0, 3));
    tbl.push_back(v(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    tbl.push_back(v(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    tbl.push_back(v(0, 1, 0, 0,    1, 1, 1, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0, 1, 0, 3));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0, 1, 0, 3));

    foreach (tbl[i]) apply(tbl[i]);

    // N=4, request 7 at cnt=1: pending through cnt=3, then 3 high / 4 low
    apply(v(1, 0, 0, 0,  0, 0, 0, 1, 0, 2));
    apply(v(0, 0, 1, 4,  0, 0, 0, 1, 0, 4));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 4));
    apply(v(0, 1, 0, 0,  1, 0, 1, 1, 0, 4));
    apply(v(0, 1, 1, 7,  0, 0, 1, 0, 0, 4));
    apply(v(0, 1, 0, 0,  0, 0, 1, 0, 0, 4));
    for (int k = 0; k < 7; k++)
      apply(v(0, 1, 0, 0,  (k < 3), (k == 0), 1, 1, 0, 7));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 7));

    // N=5, en dropped at cnt=1: period completes 2 high / 3 low, restart next cycle
    apply(v(1, 0, 0, 0,  0, 0, 0, 1, 0, 2));
    apply(v(0, 0, 1, 5,  0, 0, 0, 1, 0, 5));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 5));
    apply(v(0, 1, 0, 0,  1, 0, 1, 1, 0, 5));
    apply(v(0, 0, 0, 0,  0, 0, 1, 1, 0, 5));
    apply(v(0, 0, 0, 0,  0, 0, 1, 1, 0, 5));
    apply(v(0, 0, 0, 0,  0, 0, 1, 1, 0, 5));
    apply(v(0, 0, 0, 0,  0, 0, 0, 1, 0, 5));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 5));

    // N=3, second request while pending ignored; stop on the apply edge
    apply(v(1, 0, 0, 0,  0, 0, 0, 1, 0, 2));
    apply(v(0, 0, 1, 3,  0, 0, 0, 1, 0, 3));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 3));
    apply(v(0, 1, 1, 5,  0, 0, 1, 0, 0, 3));
    apply(v(0, 1, 1, 9,  0, 0, 1, 0, 0, 3));
    apply(v(0, 0, 0, 0,  0, 0, 0, 1, 0, 5));
    apply(v(0, 0, 0, 0,  0, 0, 0, 1, 0, 5));

    // clamped request while running: error pulse, applied as 2 at period end
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 5));
    apply(v(0, 1, 1, 1,  1, 0, 1, 0, 1, 5));
    apply(v(0, 1, 0, 0,  0, 0, 1, 0, 0, 5));
    apply(v(0, 1, 0, 0,  0, 0, 1, 0, 0, 5));
    apply(v(0, 1, 0, 0,  0, 0, 1, 0, 0, 5));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 2));
    apply(v(0, 1, 0, 0,  0, 0, 1, 1, 0, 2));
    apply(v(0, 1, 0, 0,  1, 1, 1, 1, 0, 2));

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
